// File: rtl/tx_release_sched.sv
// Holds each TX frame record until its timestamp is due, then releases it to the GMII sender; stat counters behind TX_SCHED_STATS_EN.
// Latency: 11 clocks from a pointer difference seen in IDLE to the mem_wr_ptr update, with data present and time already met.
// Backpressure: one record in flight; waits in WAIT_DATA until host_wr_ptr covers the whole record.
module tx_release_sched #(
    parameter int MIN_FRAME_LEN = 14,
    parameter int MAX_FRAME_LEN = 1514,
    parameter int HDR_WORDS     = 7
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst,
    input  logic [63:0] global_counter,
    input  logic        sched_en,
    input  logic [13:0] host_wr_ptr,
    input  logic [13:0] mem_rd_ptr,
    output logic [13:0] sched_rd_addr,
    input  logic [15:0] sched_rd_q,
    output logic [13:0] mem_wr_ptr,
    output logic [13:0] free_words,
    output logic        frame_release,
    output logic        frame_late,
    output logic        sched_error,
    output logic [31:0] stat_released,
    output logic [31:0] stat_late
);

    typedef enum logic [2:0] {
        IDLE, RD_HDR, CHECK, WAIT_DATA, WAIT_TIME, RELEASE, ERROR
    } state_t;

    typedef struct packed {
        logic [15:0] frame_len;
        logic [63:0] ts;
    } hdr_t;

    state_t      state;
    hdr_t        hdr;
    logic [2:0]  hdr_cnt;
    logic        late_q;

    logic [13:0] rec_words;
    logic [13:0] avail_words;
    logic        len_bad;
    logic        data_ok;
    logic        time_ok;
    logic        is_late;

    assign rec_words   = 14'(HDR_WORDS) + 14'((hdr.frame_len + 16'd1) >> 1);
    assign avail_words = host_wr_ptr - mem_wr_ptr;
    assign len_bad     = (hdr.frame_len < 16'(MIN_FRAME_LEN)) || (hdr.frame_len > 16'(MAX_FRAME_LEN));
    assign data_ok     = rec_words <= avail_words;
    assign time_ok     = !sched_en || (hdr.ts == 64'd0) || (global_counter >= hdr.ts);
    assign is_late     = (hdr.ts != 64'd0) && (global_counter > hdr.ts);

    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            hdr           <= '0;
            hdr_cnt       <= 3'd0;
            late_q        <= 1'b0;
            sched_rd_addr <= 14'd0;
            mem_wr_ptr    <= 14'd0;
            free_words    <= 14'd0;
            frame_release <= 1'b0;
            frame_late    <= 1'b0;
            sched_error   <= 1'b0;
        end else begin
            frame_release <= 1'b0;
            frame_late    <= 1'b0;
            free_words    <= mem_rd_ptr - host_wr_ptr - 14'd1;
            case (state)
                IDLE: begin
                    if (host_wr_ptr != mem_wr_ptr) begin
                        state         <= RD_HDR;
                        hdr_cnt       <= 3'd0;
                        sched_rd_addr <= mem_wr_ptr;
                    end
                end
                RD_HDR: begin
                    hdr_cnt <= hdr_cnt + 3'd1;
                    if (hdr_cnt < 3'd6)
                        sched_rd_addr <= mem_wr_ptr + 14'(hdr_cnt) + 14'd1;
                    // Read data trails the address by one cycle, so word k lands at hdr_cnt == k+1.
                    case (hdr_cnt)
                        3'd1:    hdr.frame_len  <= sched_rd_q;
                        3'd2:    hdr.ts[63:48] <= sched_rd_q;
                        3'd3:    hdr.ts[47:32] <= sched_rd_q;
                        3'd4:    hdr.ts[31:16] <= sched_rd_q;
                        3'd5:    hdr.ts[15:0]  <= sched_rd_q;
                        default: ;
                    endcase
                    if (hdr_cnt == 3'd7)
                        state <= CHECK;
                end
                CHECK: begin
                    if (len_bad) begin
                        sched_error <= 1'b1;
                        state       <= ERROR;
                    end else begin
                        late_q <= is_late;
                        state  <= data_ok ? WAIT_TIME : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (data_ok)
                        state <= WAIT_TIME;
                end
                WAIT_TIME: begin
                    if (time_ok)
                        state <= RELEASE;
                end
                RELEASE: begin
                    mem_wr_ptr    <= mem_wr_ptr + rec_words;
                    frame_release <= 1'b1;
                    frame_late    <= late_q;
                    state         <= IDLE;
                end
                // A bad record cannot be skipped without the sender's help, so stay put until reset.
                ERROR: ;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TX_SCHED_STATS_EN
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stat_released <= 32'd0;
            stat_late     <= 32'd0;
        end else if (state == RELEASE) begin
            stat_released <= stat_released + 32'd1;
            if (late_q)
                stat_late <= stat_late + 32'd1;
        end
    end
`else
    assign stat_released = 32'd0;
    assign stat_late     = 32'd0;
`endif

endmodule

// File: tb/tb_tx_release_sched.sv
// Bench for tx_release_sched: directed table, timed/data-wait/wrap/error/reset sequences and random records vs a record-level model.
module tb_tx_release_sched;

    logic        gmii_tx_clk = 1'b0;
    logic        sys_rst;
    logic [63:0] global_counter;
    logic        sched_en;
    logic [13:0] host_wr_ptr;
    logic [13:0] mem_rd_ptr;
    logic [13:0] sched_rd_addr;
    logic [15:0] sched_rd_q;
    logic [13:0] mem_wr_ptr;
    logic [13:0] free_words;
    logic        frame_release;
    logic        frame_late;
    logic        sched_error;
    logic [31:0] stat_released;
    logic [31:0] stat_late;

    tx_release_sched dut (
        .gmii_tx_clk    (gmii_tx_clk),
        .sys_rst        (sys_rst),
        .global_counter (global_counter),
        .sched_en       (sched_en),
        .host_wr_ptr    (host_wr_ptr),
        .mem_rd_ptr     (mem_rd_ptr),
        .sched_rd_addr  (sched_rd_addr),
        .sched_rd_q     (sched_rd_q),
        .mem_wr_ptr     (mem_wr_ptr),
        .free_words     (free_words),
        .frame_release  (frame_release),
        .frame_late     (frame_late),
        .sched_error    (sched_error),
        .stat_released  (stat_released),
        .stat_late      (stat_late)
    );

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    // Slot memory with one-cycle read latency.
    logic [15:0] mem [0:16383];
    always @(posedge gmii_tx_clk) sched_rd_q <= mem[sched_rd_addr];

    // Header address log for the wrap check.
    logic        mon_en = 1'b0;
    logic [13:0] addr_log[$];
    always @(posedge gmii_tx_clk)
        if (mon_en && (addr_log.size() == 0 || addr_log[$] != sched_rd_addr))
            addr_log.push_back(sched_rd_addr);

    int          n_chk = 0;
    int          n_fail = 0;
    logic [13:0] exp_ptr;
    int          exp_rel;
    int          exp_late;

    typedef struct {
        int          len;
        logic [63:0] ts;
        logic [63:0] gc;
        logic        en;
        logic [13:0] delta;
        logic        late;
    } vec_t;

    task automatic chk(input string name, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, what, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    function automatic logic [13:0] model_rec(input int len);
        return 14'(7 + (len + 1) / 2);
    endfunction

    task automatic chk_stats(input string name);
`ifdef TX_SCHED_STATS_EN
        chk(name, "stat_released", stat_released, exp_rel);
        chk(name, "stat_late", stat_late, exp_late);
`else
        chk(name, "stat_released", stat_released, 0);
        chk(name, "stat_late", stat_late, 0);
`endif
    endtask

    task automatic write_rec(input logic [13:0] base, input int len, input logic [63:0] ts);
        mem[base]          = 16'(len);
        mem[base + 14'd1]  = ts[63:48];
        mem[base + 14'd2]  = ts[47:32];
        mem[base + 14'd3]  = ts[31:16];
        mem[base + 14'd4]  = ts[15:0];
        mem[base + 14'd5]  = 16'($urandom);
        mem[base + 14'd6]  = 16'($urandom);
        for (int i = 0; i < (len + 1) / 2; i++)
            mem[base + 14'(7 + i)] = 16'($urandom);
    endtask

    // Present one record, watch 40 cycles, expect exactly one release of the given size.
    task automatic run_record(input string name, input int len, input logic [63:0] ts,
                              input logic [63:0] gc, input logic en, input logic [13:0] delta,
                              input logic [13:0] host, input logic exp_l, output int lat);
        logic [13:0] start;
        logic [13:0] ptr_at;
        logic        late_seen;
        logic        stray;
        int          n_rel;
        start = exp_ptr;
        write_rec(start, len, ts);
        global_counter = gc;
        sched_en       = en;
        host_wr_ptr    = host;
        n_rel = 0; lat = -1; ptr_at = start; late_seen = 1'b0; stray = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (frame_release) begin
                n_rel++;
                if (lat < 0) begin
                    lat       = cyc - 1;
                    ptr_at    = mem_wr_ptr;
                    late_seen = frame_late;
                end
            end else if (frame_late) begin
                stray = 1'b1;
            end
        end
        exp_ptr = start + delta;
        exp_rel++;
        if (exp_l) exp_late++;
        chk(name, "releases", n_rel, 1);
        chk(name, "mem_wr_ptr", ptr_at, exp_ptr);
        chk(name, "frame_late", late_seen, exp_l);
        chk(name, "late_without_release", stray, 1'b0);
    endtask

    vec_t        tbl[8];
    int          lat;
    int          rem;
    int          len;
    int          mode;
    logic [63:0] gc;
    logic [63:0] ts;
    logic        en;
    logic [13:0] start;
    logic [63:0] rel_gc;
    logic        held_bad;
    logic        late_seen;
    int          n_rel;
    int          idx;
    logic        seq_ok;

    initial begin
        tbl[0] = '{60,   64'd0,                    64'd0,                    1'b1, 14'd37,  1'b0};
        tbl[1] = '{64,   64'd500,                  64'd800,                  1'b1, 14'd39,  1'b1};
        tbl[2] = '{64,   64'd1000000000,           64'd800,                  1'b0, 14'd39,  1'b0};
        tbl[3] = '{61,   64'd800,                  64'd800,                  1'b1, 14'd38,  1'b0};
        tbl[4] = '{14,   64'hFFFF_FFFF_FFFF_FFFF,  64'h8000_0000_0000_0000,  1'b0, 14'd14,  1'b0};
        tbl[5] = '{1514, 64'd1,                    64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 14'd764, 1'b1};
        tbl[6] = '{15,   64'd0,                    64'd5,                    1'b1, 14'd15,  1'b0};
        tbl[7] = '{1513, 64'h0000_0001_0000_0000,  64'h0000_0000_FFFF_FFFF,  1'b0, 14'd764, 1'b0};

        for (int i = 0; i < 16384; i++) mem[i] = 16'd0;
        sys_rst = 1'b1; global_counter = 64'd0; sched_en = 1'b1;
        host_wr_ptr = 14'd0; mem_rd_ptr = 14'd0;
        exp_ptr = 14'd0; exp_rel = 0; exp_late = 0;
        tick(); tick();
        chk("reset", "mem_wr_ptr", mem_wr_ptr, 0);
        chk("reset", "sched_rd_addr", sched_rd_addr, 0);
        chk("reset", "free_words", free_words, 0);
        chk("reset", "frame_release", frame_release, 0);
        chk("reset", "frame_late", frame_late, 0);
        chk("reset", "sched_error", sched_error, 0);
        chk_stats("reset");

        sys_rst = 1'b0;
        mem_rd_ptr = 14'h0100;
        tick(); tick();
        chk("free_words", "rd100", free_words, 14'h00FF);
        mem_rd_ptr = 14'h0000;
        tick(); tick();
        chk("free_words", "rd0", free_words, 14'h3FFF);
        chk("idle", "mem_wr_ptr", mem_wr_ptr, 0);

        // Directed table: every entry releases without waiting, so latency is fixed.
        for (int i = 0; i < 8; i++) begin
            run_record($sformatf("table%0d", i), tbl[i].len, tbl[i].ts, tbl[i].gc, tbl[i].en,
                       tbl[i].delta, exp_ptr + tbl[i].delta, tbl[i].late, lat);
            chk($sformatf("table%0d", i), "latency", lat, 11);
        end
        chk_stats("table");

        // Timed release: counter runs up from 900 to timestamp 1000.
        start = exp_ptr;
        write_rec(start, 64, 64'd1000);
        global_counter = 64'd900; sched_en = 1'b1; host_wr_ptr = start + 14'd39;
        held_bad = 1'b0; rel_gc = 64'd0; n_rel = 0; late_seen = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            global_counter = global_counter + 64'd1;
            if (frame_release) begin
                n_rel++;
                rel_gc = global_counter;
                late_seen = frame_late;
            end
            if (global_counter < 64'd1000 && mem_wr_ptr != start) held_bad = 1'b1;
        end
        exp_ptr = start + 14'd39; exp_rel++;
        chk("timed", "held_before_ts", held_bad, 1'b0);
        chk("timed", "releases", n_rel, 1);
        chk("timed", "release_window", (rel_gc >= 64'd1000 && rel_gc <= 64'd1002), 1'b1);
        chk("timed", "frame_late", late_seen, 1'b0);
        chk("timed", "mem_wr_ptr", mem_wr_ptr, exp_ptr);

        // Data wait: host pointer five words short of the record.
        start = exp_ptr;
        write_rec(start, 100, 64'd0);
        global_counter = 64'd0; host_wr_ptr = start + 14'd57 - 14'd5;
        n_rel = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (frame_release) n_rel++;
        end
        chk("data_wait", "no_release", n_rel, 0);
        chk("data_wait", "mem_wr_ptr_held", mem_wr_ptr, start);
        host_wr_ptr = start + 14'd57;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (frame_release) n_rel++;
        end
        exp_ptr = start + 14'd57; exp_rel++;
        chk("data_wait", "released", n_rel, 1);
        chk("data_wait", "mem_wr_ptr", mem_wr_ptr, exp_ptr);

        // Random records against the record-level model.
        for (int r = 0; r < 20; r++) begin
            len  = $urandom_range(14, 1514);
            mode = $urandom_range(0, 3);
            gc   = {32'($urandom), 32'($urandom)} | 64'h1_0000;
            en   = 1'($urandom);
            case (mode)
                0:       ts = 64'd0;
                1:       ts = gc - 64'($urandom_range(1, 1000));
                2:       begin ts = gc; en = 1'b1; end
                default: begin ts = gc + 64'($urandom_range(1, 1000000)); en = 1'b0; end
            endcase
            run_record($sformatf("rand%0d", r), len, ts, gc, en, model_rec(len),
                       exp_ptr + model_rec(len), (ts != 64'd0) && (gc > ts), lat);
        end
        chk_stats("random");

        // Fill up to 0x3FF8 for the wrap record.
        rem = int'(14'h3FF8 - exp_ptr);
        while (rem > 778) begin
            run_record("fill", 1514, 64'd0, 64'd0, 1'b1, 14'd764, exp_ptr + 14'd764, 1'b0, lat);
            rem -= 764;
        end
        if (rem > 764) begin
            run_record("fill", 2 * (rem - 21), 64'd0, 64'd0, 1'b1, 14'(rem - 14), exp_ptr + 14'(rem - 14), 1'b0, lat);
            rem = 14;
        end
        if (rem >= 14)
            run_record("fill", 2 * (rem - 7), 64'd0, 64'd0, 1'b1, 14'(rem), exp_ptr + 14'(rem), 1'b0, lat);
        chk("fill", "mem_wr_ptr", mem_wr_ptr, 14'h3FF8);

        // Wrap record, followed by a bad-length record at 0x001E.
        write_rec(14'h001E, 2000, 64'd0);
        addr_log.delete();
        mon_en = 1'b1;
        run_record("wrap", 61, 64'd0, 64'd0, 1'b1, 14'd38, 14'h0020, 1'b0, lat);
        mon_en = 1'b0;
        chk("wrap", "mem_wr_ptr_abs", mem_wr_ptr, 14'h001E);
        idx = -1;
        for (int i = 0; i < addr_log.size(); i++)
            if (idx < 0 && addr_log[i] == 14'h3FF8) idx = i;
        seq_ok = (idx >= 0) && (idx + 6 < addr_log.size());
        if (seq_ok)
            for (int k = 0; k < 7; k++)
                if (addr_log[idx + k] != 14'h3FF8 + 14'(k)) seq_ok = 1'b0;
        chk("wrap", "hdr_addr_seq", seq_ok, 1'b1);

        chk("error", "sched_error", sched_error, 1'b1);
        chk("error", "mem_wr_ptr_frozen", mem_wr_ptr, 14'h001E);
        host_wr_ptr = 14'h0300;
        n_rel = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (frame_release) n_rel++;
        end
        chk("error", "sticky", sched_error, 1'b1);
        chk("error", "still_frozen", mem_wr_ptr, 14'h001E);
        chk("error", "no_release", n_rel, 0);

        // Reset in the middle of a header read.
        host_wr_ptr = 14'd0;
        sys_rst = 1'b1; tick();
        chk("reset2", "sched_error", sched_error, 1'b0);
        sys_rst = 1'b0;
        exp_ptr = 14'd0; exp_rel = 0; exp_late = 0;
        mem_rd_ptr = 14'h0200;
        write_rec(14'd0, 60, 64'd0);
        host_wr_ptr = 14'h0025;
        tick(); tick(); tick(); tick();
        chk("mid_rst", "addr_busy", (sched_rd_addr != 14'd0), 1'b1);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst", "mem_wr_ptr", mem_wr_ptr, 0);
        chk("mid_rst", "sched_rd_addr", sched_rd_addr, 0);
        chk("mid_rst", "free_words", free_words, 0);
        chk("mid_rst", "frame_release", frame_release, 0);
        chk("mid_rst", "sched_error", sched_error, 0);
        chk_stats("mid_rst");
        tick();
        sys_rst = 1'b0;
        run_record("post_rst", 60, 64'd0, 64'd0, 1'b1, 14'd37, 14'h0025, 1'b0, lat);
        chk_stats("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
